// File: rtl/trace_pkg.sv
// Shared definitions for the instruction-trace UART: serializer states,
// record layout constants and the nibble-to-ASCII conversion.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    localparam int RECORD_LEN = 19;

    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Uppercase hex: 0-9 -> '0'-'9', A-F -> 'A'-'F' ('A' - 10 = 0x37).
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A byte is taken when valid_i && ready_o; ready_o is
// high in IDLE and in the final cycle of a stop bit, so bytes chain with no gap.
module uart_tx_byte
    import trace_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       tx_o,
    output tx_state_e  state_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             tick;

    assign tick    = (baud_q == BAUD_LAST);
    assign ready_o = (state_q == ST_IDLE) || ((state_q == ST_STOP) && tick);
    assign tx_o    = tx_q;
    assign state_o = state_q;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        baud_d  = ((state_q == ST_IDLE) || tick) ? '0 : baud_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    state_d = ST_START;
                    shift_d = data_i;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (valid_i) begin
                        state_d = ST_START;
                        shift_d = data_i;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/trace_uart_tx.sv
// Instruction-trace UART: captures one retired step (addr, instr) and sends
// it as "AAAAAAAA IIIIIIII\r\n"; steps arriving while busy are dropped and counted.
module trace_uart_tx
    import trace_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115200
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] instr_i,
    output logic        tx_o,
    output logic        busy_o,
    output logic        drop_o,
    output logic [7:0]  drop_cnt_o
);

    localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;

    logic        busy_q, busy_d;
    logic [63:0] hold_q, hold_d;
    logic [4:0]  idx_q, idx_d;
    logic        drop_q, drop_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    logic        accept, last_stop, byte_valid, ser_ready;
    logic [4:0]  sel;
    logic [63:0] rec;
    logic [3:0]  ni;
    logic [7:0]  byte_data;
    tx_state_e   ser_state;

    assign accept     = valid_i && !busy_q;
    assign last_stop  = (ser_state == ST_STOP) && ser_ready;
    assign byte_valid = accept || (busy_q && (idx_q < 5'(RECORD_LEN - 1)));
    assign sel        = busy_q ? idx_q + 5'd1 : 5'd0;

    // Byte 0 is fed straight from the inputs in the accept cycle so the start
    // bit appears on the very next cycle; later bytes come from the holding register.
    always_comb begin
        rec       = busy_q ? hold_q : {addr_i, instr_i};
        ni        = 4'd0;
        byte_data = ASCII_LF;
        if (sel < 5'd8) begin
            ni        = 4'(5'd15 - sel);
            byte_data = hex_ascii(rec[{ni, 2'b00} +: 4]);
        end else if (sel == 5'd8) begin
            byte_data = ASCII_SP;
        end else if (sel < 5'd17) begin
            ni        = 4'(5'd16 - sel);
            byte_data = hex_ascii(rec[{ni, 2'b00} +: 4]);
        end else if (sel == 5'd17) begin
            byte_data = ASCII_CR;
        end
    end

    always_comb begin
        busy_d     = busy_q;
        hold_d     = hold_q;
        idx_d      = idx_q;
        drop_d     = valid_i && busy_q;
        drop_cnt_d = drop_cnt_q;
        if (accept) begin
            busy_d = 1'b1;
            hold_d = {addr_i, instr_i};
        end
        if (byte_valid && ser_ready) begin
            idx_d = sel;
        end
        if (busy_q && last_stop && (idx_q == 5'(RECORD_LEN - 1))) begin
            busy_d = 1'b0;
        end
        if (drop_d && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q     <= 1'b0;
            hold_q     <= 64'h0;
            idx_q      <= 5'd0;
            drop_q     <= 1'b0;
            drop_cnt_q <= 8'h00;
        end else begin
            busy_q     <= busy_d;
            hold_q     <= hold_d;
            idx_q      <= idx_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    uart_tx_byte #(.DIV(DIV)) u_ser (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (byte_valid),
        .data_i  (byte_data),
        .ready_o (ser_ready),
        .tx_o    (tx_o),
        .state_o (ser_state)
    );

    assign busy_o     = busy_q;
    assign drop_o     = drop_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule
